// File: rtl/systolic_feeder.sv
// Operand sequencer for the systolic GEMM core: per-lane input skew plus tile sequencing (clear, stream, drain, done).
// Latency: a beat accepted at edge e appears on act lane r at e+1+r and on wgt lane c at e+1+c; done follows the last beat by DRAIN_CYCLES+1.
// Backpressure: operand_ready is high only while streaming; the skew pipelines never stall and fill with bubbles instead.
module systolic_feeder #(
  parameter int PE_ROWS      = 4,
  parameter int PE_COLS      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int K_WIDTH      = 8,
  parameter int DRAIN_CYCLES = PE_ROWS + PE_COLS + 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [K_WIDTH-1:0]               k_len,
  output logic                             busy,
  output logic                             done,
  input  logic [PE_ROWS*DATA_WIDTH-1:0]    a_vec_in,
  input  logic [PE_COLS*WEIGHT_WIDTH-1:0]  w_vec_in,
  input  logic                             operand_valid,
  output logic                             operand_ready,
  output logic                             clear_accum,
  output logic [PE_ROWS*DATA_WIDTH-1:0]    act_out,
  output logic [PE_ROWS-1:0]               act_valid_out,
  output logic [PE_COLS*WEIGHT_WIDTH-1:0]  wgt_out,
  output logic [PE_COLS-1:0]               wgt_valid_out
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [K_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
  logic               busy_q, done_q, clear_q;
  logic               beat_fire;

  assign operand_ready = (state_q == S_STREAM);
  assign beat_fire     = operand_valid && operand_ready;
  assign busy          = busy_q;
  assign done          = done_q;
  assign clear_accum   = clear_q;

  // Next-state logic for the tile sequencer and its beat/drain counters.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          k_len_d    = k_len;
          beat_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        drain_cnt_d = '0;
        state_d     = (k_len_q == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
          // k_len_q is non-zero here, so the subtraction cannot wrap.
          if (beat_cnt_q == k_len_q - K_WIDTH'(1)) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered state decodes (outputs track the state being entered).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      clear_q     <= (state_d == S_CLEAR);
    end
  end

  // Activation skew: lane r runs through r+1 stages; bubbles carry zero data.
  for (genvar r = 0; r < PE_ROWS; r++) begin : g_act
    logic [DATA_WIDTH-1:0] dat_q [r+1];
    logic                  vld_q [r+1];

    // Shift the lane every cycle, loading stage 0 with the beat or a bubble.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= r; s++) begin
          dat_q[s] <= '0;
          vld_q[s] <= 1'b0;
        end
      end else begin
        dat_q[0] <= beat_fire ? a_vec_in[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        vld_q[0] <= beat_fire;
        for (int s = 1; s <= r; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    assign act_out[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r];
    assign act_valid_out[r]                    = vld_q[r];
  end

  // Weight skew: lane c runs through c+1 stages, matching the activation skew.
  for (genvar c = 0; c < PE_COLS; c++) begin : g_wgt
    logic [WEIGHT_WIDTH-1:0] dat_q [c+1];
    logic                    vld_q [c+1];

    // Shift the lane every cycle, loading stage 0 with the beat or a bubble.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= c; s++) begin
          dat_q[s] <= '0;
          vld_q[s] <= 1'b0;
        end
      end else begin
        dat_q[0] <= beat_fire ? w_vec_in[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
        vld_q[0] <= beat_fire;
        for (int s = 1; s <= c; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    assign wgt_out[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = dat_q[c];
    assign wgt_valid_out[c]                        = vld_q[c];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table of tiles plus reset sequences.
// Expected lane outputs come from a scoreboard filled when beats are driven.
// Tile-level results (done offset, ready cycles) are checked against table constants.
module tb_systolic_feeder;
  localparam int PR = 4;
  localparam int PC = 4;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int KW = 8;
  localparam int D  = PR + PC + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              busy, done;
  logic [PR*DW-1:0]  a_vec_in;
  logic [PC*WW-1:0]  w_vec_in;
  logic              operand_valid, operand_ready, clear_accum;
  logic [PR*DW-1:0]  act_out;
  logic [PR-1:0]     act_valid_out;
  logic [PC*WW-1:0]  wgt_out;
  logic [PC-1:0]     wgt_valid_out;

  systolic_feeder #(
    .PE_ROWS(PR), .PE_COLS(PC), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
    .K_WIDTH(KW), .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .a_vec_in(a_vec_in), .w_vec_in(w_vec_in),
    .operand_valid(operand_valid), .operand_ready(operand_ready),
    .clear_accum(clear_accum), .act_out(act_out), .act_valid_out(act_valid_out),
    .wgt_out(wgt_out), .wgt_valid_out(wgt_valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [15:0] vpat;          // valid per stream cycle index (1 beyond bit 15)
    logic [15:0] base;          // data seed
    bit          junk;          // drive valid=1 outside STREAM
    bit          abuse;         // pulse start during STREAM
    int          rst_at;        // stream cycle index to assert reset, -1 none
    int          exp_done_off;  // edges from start edge to done, -1 none
    int          exp_ready;     // cycles with operand_ready high
  } tile_vec_t;

  typedef struct {
    bit          is_w;
    int          lane;
    int          due;
    logic [15:0] dat;
  } sb_item_t;

  tile_vec_t tbl[9];
  sb_item_t  sb[$];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  bit tile_active = 1'b0;
  int t_s = 0, k_cur = 0, beats = 0, last_e = -1;
  int done_seen, done_edge, ready_cnt, clear_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  function automatic int end_edge();
    if (k_cur == 0) return t_s + D + 1;
    if (last_e >= 0) return last_e + D;
    return -1;
  endfunction

  task automatic expect_lane(input bit is_w, input int lane, output logic v, output logic [15:0] d);
    v = 1'b0;
    d = '0;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].is_w == is_w && sb[i].lane == lane && sb[i].due == edge_n) begin
        v = 1'b1;
        d = sb[i].dat;
        sb.delete(i);
        break;
      end
    end
  endtask

  task automatic check_outputs();
    int          ee;
    logic        eb, er, ec, ed, lv;
    logic [15:0] ld;
    ee = end_edge();
    er = tile_active && edge_n >= t_s + 1 && beats < k_cur;
    ec = tile_active && edge_n == t_s;
    eb = tile_active && (ee < 0 || edge_n <= ee);
    ed = tile_active && edge_n == ee;
    chk("busy", busy, eb);
    chk("operand_ready", operand_ready, er);
    chk("clear_accum", clear_accum, ec);
    chk("done", done, ed);
    if (done) begin
      done_seen++;
      done_edge = edge_n;
    end
    ready_cnt += int'(operand_ready);
    clear_cnt += int'(clear_accum);
    for (int r = 0; r < PR; r++) begin
      expect_lane(1'b0, r, lv, ld);
      chk($sformatf("act_vld[%0d]", r), act_valid_out[r], lv);
      chk($sformatf("act_dat[%0d]", r), act_out[r*DW +: DW], ld);
    end
    for (int c = 0; c < PC; c++) begin
      expect_lane(1'b1, c, lv, ld);
      chk($sformatf("wgt_vld[%0d]", c), wgt_valid_out[c], lv);
      chk($sformatf("wgt_dat[%0d]", c), wgt_out[c*WW +: WW], ld[WW-1:0]);
    end
    if (tile_active && ee >= 0 && edge_n == ee + 1) tile_active = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
    check_outputs();
  endtask

  task automatic drive_idle(input bit junk);
    operand_valid = junk;
    a_vec_in      = {PR{16'hBEEF}};
    w_vec_in      = {PC{8'hA5}};
  endtask

  task automatic run_tile(input tile_vec_t v);
    int          guard, pc;
    logic [15:0] av;
    logic [7:0]  wv;
    done_seen = 0; done_edge = -1; ready_cnt = 0; clear_cnt = 0;
    start = 1'b1;
    k_len = v.k[KW-1:0];
    drive_idle(v.junk);
    t_s = edge_n + 1; k_cur = v.k; beats = 0; last_e = -1; tile_active = 1'b1;
    tick();
    guard = 0;
    while (tile_active && guard < 600) begin
      start = 1'b0;
      rst_n = 1'b1;
      if (edge_n >= t_s + 1 && beats < k_cur) begin
        pc = edge_n - (t_s + 1);
        start = v.abuse && pc == 1;
        operand_valid = (pc < 16) ? v.vpat[pc] : 1'b1;
        a_vec_in = {PR{16'hBEEF}};
        w_vec_in = {PC{8'hA5}};
        if (operand_valid) begin
          for (int r = 0; r < PR; r++) a_vec_in[r*DW +: DW] = v.base + 16'(beats*16 + r + 1);
          for (int c = 0; c < PC; c++) w_vec_in[c*WW +: WW] = 8'(v.base + 16'(beats*16 + c + 5));
        end
        if (pc == v.rst_at) begin
          rst_n = 1'b0;
          tile_active = 1'b0;
          sb.delete();
        end else if (operand_valid) begin
          for (int r = 0; r < PR; r++) begin
            av = a_vec_in[r*DW +: DW];
            sb.push_back('{is_w: 1'b0, lane: r, due: edge_n + 1 + r, dat: av});
          end
          for (int c = 0; c < PC; c++) begin
            wv = w_vec_in[c*WW +: WW];
            sb.push_back('{is_w: 1'b1, lane: c, due: edge_n + 1 + c, dat: {8'h00, wv}});
          end
          beats++;
          if (beats == k_cur) last_e = edge_n + 1;
        end
      end else begin
        drive_idle(v.junk);
      end
      tick();
      guard++;
    end
    rst_n = 1'b1;
    start = 1'b0;
    chk("tile_timeout", tile_active, 1'b0);
    if (v.rst_at >= 0) begin
      // After an abort the block must sit idle: no late done, no output valids.
      repeat (12) begin
        drive_idle(1'b1);
        tick();
      end
    end
    chk("done_count", done_seen, (v.exp_done_off >= 0) ? 1 : 0);
    if (v.exp_done_off >= 0) chk("done_offset", done_edge - t_s, v.exp_done_off);
    chk("ready_cycles", ready_cnt, v.exp_ready);
    chk("clear_count", clear_cnt, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //         k    vpat      base      junk abuse rst  done ready
    tbl[0] = '{k: 1,   vpat: 16'hFFFF, base: 16'h0000, junk: 0, abuse: 0, rst_at: -1, exp_done_off: 12,  exp_ready: 1};
    tbl[1] = '{k: 4,   vpat: 16'hFFFF, base: 16'h0100, junk: 1, abuse: 0, rst_at: -1, exp_done_off: 15,  exp_ready: 4};
    tbl[2] = '{k: 4,   vpat: 16'hFFF3, base: 16'h7F00, junk: 0, abuse: 0, rst_at: -1, exp_done_off: 17,  exp_ready: 6};
    tbl[3] = '{k: 0,   vpat: 16'hFFFF, base: 16'h0000, junk: 1, abuse: 0, rst_at: -1, exp_done_off: 11,  exp_ready: 0};
    tbl[4] = '{k: 2,   vpat: 16'hFFFA, base: 16'h8000, junk: 1, abuse: 0, rst_at: -1, exp_done_off: 15,  exp_ready: 4};
    tbl[5] = '{k: 3,   vpat: 16'hFFFF, base: 16'h0200, junk: 0, abuse: 1, rst_at: -1, exp_done_off: 14,  exp_ready: 3};
    tbl[6] = '{k: 8,   vpat: 16'hFFFF, base: 16'h0300, junk: 1, abuse: 0, rst_at: 3,  exp_done_off: -1,  exp_ready: 4};
    tbl[7] = '{k: 4,   vpat: 16'hFFFF, base: 16'h0055, junk: 0, abuse: 0, rst_at: -1, exp_done_off: 15,  exp_ready: 4};
    tbl[8] = '{k: 255, vpat: 16'hFFFF, base: 16'h1234, junk: 0, abuse: 0, rst_at: -1, exp_done_off: 266, exp_ready: 255};

    // Reset held with start and operand_valid asserted: everything stays at zero.
    rst_n = 1'b0;
    start = 1'b1;
    k_len = 8'd5;
    drive_idle(1'b1);
    repeat (3) tick();
    rst_n = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
    drive_idle(1'b0);
    repeat (2) tick();

    for (int i = 0; i < 9; i++) run_tile(tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand sequencer that drives the input edges of the `systolic_array` GEMM core for the GPT-2 ASIC. It accepts one k-step per beat over a valid/ready handshake: a column of the activation tile (PE_ROWS values) plus a row of the weight tile (PE_COLS values). It re-times each lane with a per-lane skew so that PE(r,c) receives a[r][k] and w[k][c] in the same cycle. It also sequences the tile: it pulses the array's accumulator clear, streams k_len beats, waits out the array pipeline, then signals done.

## Interface
- PE_ROWS, 4, array rows (activation lanes)
- PE_COLS, 4, array columns (weight lanes)
- DATA_WIDTH, 16, activation width (S5.10)
- WEIGHT_WIDTH, 8, weight width (S1.6)
- K_WIDTH, 8, width of k_len; max inner dimension 2^K_WIDTH-1
- DRAIN_CYCLES, PE_ROWS+PE_COLS+2, cycles waited after the last beat before done

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a tile; sampled only in IDLE
- k_len  in  K_WIDTH  inner dimension; latched on start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of tile
- a_vec_in  in  PE_ROWS*DATA_WIDTH  activation column; lane r at [r*DATA_WIDTH +: DATA_WIDTH]
- w_vec_in  in  PE_COLS*WEIGHT_WIDTH  weight row; lane c at [c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- operand_valid  in  1  upstream beat valid
- operand_ready  out  1  feeder accepts a beat this cycle
- clear_accum  out  1  to array global_clear_accum
- act_out  out  PE_ROWS*DATA_WIDTH  to activations_in_L, same lane packing
- act_valid_out  out  PE_ROWS  to activations_valid_in_L
- wgt_out  out  PE_COLS*WEIGHT_WIDTH  to weights_in_T
- wgt_valid_out  out  PE_COLS  to weights_valid_in_T

## Operation
- FSM states and transitions:
  - IDLE: start=1 moves to CLEAR and latches k_len.
  - CLEAR: lasts exactly 1 cycle, then goes to STREAM, or to DRAIN if k_len=0.
  - STREAM: leaves for DRAIN on the edge that accepts beat number k_len.
  - DRAIN: lasts exactly DRAIN_CYCLES cycles, then goes to DONE.
  - DONE: lasts 1 cycle, then returns to IDLE.
- clear_accum=1 only during CLEAR, and done=1 only during DONE. Both are registered state decodes.
- operand_ready = (state==STREAM). A beat is accepted when operand_valid && operand_ready at a rising edge. A beat counter counts accepted beats.
- Skew: activation lane r is delayed through r+1 register stages; weight lane c through c+1 stages. Stage 0 of every lane is loaded on each edge with the accepted beat, or with a bubble if no beat is accepted.
- Each stage carries both a valid bit and data. A bubble has valid=0 and data=0, so an output's data is 0 whenever its valid is 0.
- Stalls (operand_valid=0 in STREAM) insert bubbles. Activations and weights take identical skew, so alignment at every PE is preserved.
- start while busy is ignored. operand_valid outside STREAM is ignored, and nothing is consumed.
- Skew pipelines keep shifting in every state, so beats accepted late in STREAM drain out during DRAIN.

## Timing
- Reset: on the first edge with rst_n=0, the following are all forced to 0: state (IDLE), counters, all skew stages, busy, done, clear_accum, act_out, act_valid_out, wgt_out, wgt_valid_out. operand_ready is 0 as a consequence of IDLE.
- Reset mid-tile aborts the tile: no done pulse, and in-flight skew contents are discarded.
- Start sampled at edge t:
  - Cycle t+1: CLEAR. clear_accum=1, busy=1.
  - Cycle t+2: STREAM. operand_ready=1.
- Beat accepted at edge e: act lane r shows it in cycle e+1+r; wgt lane c shows it in cycle e+1+c.
- Last beat accepted at edge L: operand_ready=0 from cycle L+1. DRAIN covers cycles L+1..L+DRAIN_CYCLES, done=1 in cycle L+DRAIN_CYCLES+1, and busy falls in the following cycle.
- k_len=0, start at t: CLEAR in t+1, DRAIN in t+2..t+1+DRAIN_CYCLES, done in t+2+DRAIN_CYCLES. No valid outputs in that window.
- Back-to-back tiles: start may be asserted in the done cycle's successor (IDLE). Minimum gap between done and the next clear_accum is 2 cycles.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 and operand_valid=1 → every output is 0, no clear_accum, and busy stays 0 until start after release.
- Single beat: k_len=1, a_vec=[1,2,3,4], w_vec=[5,6,7,8], accepted at edge e →
  - act lane r is valid only in cycle e+1+r with value r+1.
  - wgt lane c is valid only in cycle e+1+c with value c+5.
  - done occurs at e+DRAIN_CYCLES+1.
- Streaming: k_len=4 with operand_valid held 1 → operand_ready high exactly 4 cycles; each lane valid for 4 consecutive cycles with lane r starting r cycles after lane 0; exactly one clear_accum and one done pulse.
- Bubble: k_len=4 with operand_valid low for 2 cycles after beat 2 → the same 2-cycle valid gap appears on every lane, shifted by the lane skew; 4 beats are consumed in total; data=0 during the gaps.
- Zero length: k_len=0 → clear_accum pulse, operand_ready never high, no output valids, done 2+DRAIN_CYCLES cycles after the start edge.
- Abuse: start pulsed during STREAM is ignored (one done only); rst_n=0 during STREAM → all outputs 0 on the next cycle, no done, and a new start then runs a normal tile.
